// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: req/gnt/rvalid imem master with an in-order prefetch FIFO,
// redirect squashing of in-flight responses and a halt on misaligned redirect targets.
module cpu_fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_insn_valid,
  input  logic            i_insn_ready,
  output logic [31:0]     o_insn,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_incr,
  output logic            o_misaligned,
  output logic            o_halted
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PqW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic [OutW-1:0] drop_q, drop_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PqW-1:0]  pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic            misaligned_q, misaligned_d;

  logic [31:0]     insn_q    [FIFO_DEPTH];
  logic [XLEN-1:0] pc_q      [FIFO_DEPTH];
  logic [XLEN-1:0] pc_incr_q [FIFO_DEPTH];
  logic [XLEN-1:0] pcq_q     [MAX_OUTSTANDING];

  logic imem_req, issue, push, pop, insn_valid, credit_ok;

  function automatic logic [PqW-1:0] pq_next(input logic [PqW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PqW'(1);
  endfunction

  // Credit counts in-flight words too, so every granted response has a FIFO slot.
  always_comb begin
    credit_ok  = ((32'(count_q) + 32'(outstanding_q)) < FIFO_DEPTH) &&
                 (32'(outstanding_q) < MAX_OUTSTANDING);
    imem_req   = i_rst_n && (state_q == StRun) && !i_redirect_valid && credit_ok;
    issue      = imem_req && i_imem_gnt;
    insn_valid = (count_q != '0);
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pcq_wr_d      = pcq_wr_q;
    pcq_rd_d      = pcq_rd_q;
    misaligned_d  = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      pcq_wr_d   = pq_next(pcq_wr_q);
    end
    if (i_imem_rvalid) begin
      pcq_rd_d = pq_next(pcq_rd_q);
    end
    if (issue && !i_imem_rvalid) begin
      outstanding_d = outstanding_q + OutW'(1);
    end else if (!issue && i_imem_rvalid) begin
      outstanding_d = outstanding_q - OutW'(1);
    end

    if (i_redirect_valid) begin
      // Every response still in flight after this cycle belongs to the old stream.
      drop_d       = outstanding_d;
      count_d      = '0;
      rd_ptr_d     = wr_ptr_q;
      fetch_pc_d   = i_redirect_pc;
      misaligned_d = |i_redirect_pc[1:0];
      state_d      = misaligned_d ? StHalt : StRun;
    end else begin
      if (i_imem_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - OutW'(1);
        end else begin
          push = 1'b1;
        end
      end
      pop = insn_valid && i_insn_ready;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // Storage is reset so the head outputs read as zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        insn_q[i]    <= '0;
        pc_q[i]      <= '0;
        pc_incr_q[i] <= '0;
      end
      for (int unsigned j = 0; j < MAX_OUTSTANDING; j++) begin
        pcq_q[j] <= '0;
      end
    end else begin
      if (push) begin
        insn_q[wr_ptr_q]    <= i_imem_rdata;
        pc_q[wr_ptr_q]      <= pcq_q[pcq_rd_q];
        pc_incr_q[wr_ptr_q] <= pcq_q[pcq_rd_q] + XLEN'(4);
      end
      if (issue) begin
        pcq_q[pcq_wr_q] <= fetch_pc_q;
      end
    end
  end

  assign o_imem_req   = imem_req;
  assign o_imem_addr  = fetch_pc_q;
  assign o_insn_valid = insn_valid;
  assign o_insn       = insn_q[rd_ptr_q];
  assign o_pc         = pc_q[rd_ptr_q];
  assign o_pc_incr    = pc_incr_q[rd_ptr_q];
  assign o_misaligned = misaligned_q;
  assign o_halted     = (state_q == StHalt);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push && (32'(count_q) == FIFO_DEPTH)));
  a_no_spurious_rvalid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_imem_rvalid && (outstanding_q == '0)));

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Randomised bench for cpu_fetch_unit: an imem responder tags every request with a redirect
// epoch; only current-epoch words are expected at decode, in fetch order.
module tb_cpu_fetch_unit;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_imem_req, o_insn_valid, o_misaligned, o_halted;
  logic [31:0] o_imem_addr, o_insn, o_pc, o_pc_incr;
  logic        i_imem_gnt = 1'b0, i_imem_rvalid = 1'b0, i_redirect_valid = 1'b0;
  logic        i_insn_ready = 1'b0;
  logic [31:0] i_imem_rdata = '0, i_redirect_pc = '0;

  always #5 clk = ~clk;

  cpu_fetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_insn_valid(o_insn_valid), .i_insn_ready(i_insn_ready), .o_insn(o_insn),
    .o_pc(o_pc), .o_pc_incr(o_pc_incr), .o_misaligned(o_misaligned), .o_halted(o_halted)
  );

  typedef struct { logic [31:0] insn; logic [31:0] pc; } exp_t;
  typedef struct { logic [31:0] addr; int unsigned epoch; int unsigned due; } req_t;

  exp_t        sb[$];
  req_t        inflight[$];
  int unsigned tests = 0, fails = 0, pops = 0;
  int unsigned cyc = 0, epoch = 0;
  logic [31:0] m_pc = RESET_PC;
  bit          m_halt = 0, m_mis = 0;
  int unsigned gnt_pct = 100, rdy_pct = 100, rv_pct = 100, lat_max = 0, redir_pm = 0;
  bit          force_redir = 0, run = 0;
  logic [31:0] force_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver plus imem responder; the model state advances just after each posedge.
  initial begin : driver
    bit          rv, redir, issue, exp_req;
    logic [31:0] tgt;
    req_t        r;
    forever begin
      @(negedge clk);
      if (!run) begin
        i_imem_gnt = 0; i_imem_rvalid = 0; i_redirect_valid = 0; i_insn_ready = 0;
        continue;
      end
      i_imem_gnt = ($urandom_range(99) < gnt_pct);
      rv = (inflight.size() > 0) && (inflight[0].due <= cyc) && ($urandom_range(99) < rv_pct);
      i_imem_rvalid = rv;
      i_imem_rdata  = rv ? mem_word(inflight[0].addr) : $urandom;
      redir = force_redir || ($urandom_range(999) < redir_pm);
      case ($urandom_range(9))
        0:       tgt = 32'hFFFF_FFF0 + ($urandom_range(3) << 2);
        1:       tgt = ($urandom_range(1023) << 2) | $urandom_range(3, 1);
        default: tgt = $urandom_range(1023) << 2;
      endcase
      if (force_redir) tgt = force_pc;
      force_redir      = 0;
      i_redirect_valid = redir;
      i_redirect_pc    = tgt;
      i_insn_ready     = ($urandom_range(99) < rdy_pct);
      #1;
      exp_req = !m_halt && !redir && (sb.size() + inflight.size() < DEPTH) &&
                (inflight.size() < MAXO);
      check("imem_req", o_imem_req, exp_req);
      if (exp_req) check("imem_addr", o_imem_addr, m_pc);
      check("halted", o_halted, m_halt);
      check("misaligned", o_misaligned, m_mis);
      issue = exp_req && i_imem_gnt;
      @(posedge clk);
      cyc++;
      if (rv) begin
        r = inflight.pop_front();
        if (!redir && r.epoch == epoch) sb.push_back('{insn: mem_word(r.addr), pc: r.addr});
      end
      m_mis = 0;
      if (redir) begin
        sb.delete();
        epoch++;
        m_pc   = tgt;
        m_halt = (tgt[1:0] != 2'b00);
        m_mis  = m_halt;
      end else if (issue) begin
        r.addr  = m_pc;
        r.epoch = epoch;
        r.due   = cyc + $urandom_range(lat_max);
        if (inflight.size() > 0 && r.due < inflight[$].due) r.due = inflight[$].due;
        inflight.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Monitor: compares the decode-side head against the scoreboard on every pop.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (run) begin
        check("insn_valid", o_insn_valid, sb.size() > 0);
        if (sb.size() > 0 && i_insn_ready && !i_redirect_valid) begin
          e = sb.pop_front();
          check("insn", o_insn, e.insn);
          check("pc", o_pc, e.pc);
          check("pc_incr", o_pc_incr, e.pc + 32'd4);
          pops++;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, o_imem_req, 0);
    check({tag, "_addr"}, o_imem_addr, RESET_PC);
    check({tag, "_valid"}, o_insn_valid, 0);
    check({tag, "_insn"}, o_insn, 0);
    check({tag, "_pc"}, o_pc, 0);
    check({tag, "_pc_incr"}, o_pc_incr, 0);
    check({tag, "_misaligned"}, o_misaligned, 0);
    check({tag, "_halted"}, o_halted, 0);
  endtask

  initial begin : main
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    @(posedge clk);
    run = 1;

    // Streaming at latency 1 with decode always ready.
    repeat (10) @(posedge clk);

    // Decode stalled: FIFO fills to DEPTH and requests stop.
    rdy_pct = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #3;
    check("fill_req_low", o_imem_req, 0);
    check("fill_valid", o_insn_valid, 1);
    rdy_pct = 100;
    repeat (6) @(posedge clk);

    // Grant withheld: address must hold.
    gnt_pct = 0;
    repeat (3) @(posedge clk);
    gnt_pct = 100;
    repeat (4) @(posedge clk);

    // Redirect with slower memory so words are in flight.
    lat_max = 1;
    repeat (3) @(posedge clk);
    force_pc = 32'h100; force_redir = 1;
    repeat (8) @(posedge clk);

    // Misaligned redirect halts; an aligned one resumes.
    force_pc = 32'h102; force_redir = 1;
    repeat (6) @(posedge clk);
    force_pc = 32'h200; force_redir = 1;
    repeat (8) @(posedge clk);

    // Fetch across the top of the address space.
    lat_max = 0;
    force_pc = 32'hFFFF_FFF4; force_redir = 1;
    repeat (10) @(posedge clk);

    // Randomised traffic.
    gnt_pct = 70; rdy_pct = 60; rv_pct = 60; lat_max = 3; redir_pm = 40;
    repeat (3000) @(posedge clk);

    run = 0;
    repeat (2) @(posedge clk);
    check("pop_liveness", pops >= 100, 1);

    // Reset mid-operation.
    @(negedge clk);
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
